ordena_frame_loader: RTL and testbench

- Upstream feeder for the 8-input combinational sorter `ordener2`.
- Accepts a serial byte stream over a valid/ready handshake and packs up to 8 bytes into one frame.
- Short frames (terminated by `in_last`) are padded to 8 slots with `PAD_VAL`.
- Presents the frame in parallel on a–h with a held `out_valid` until the consumer acknowledges it.

---
 rtl/ordena_frame_loader_pkg.sv | 19 +
 rtl/ordena_frame_loader_if.sv | 29 ++
 rtl/ordena_frame_loader.sv | 136 +++++++++++++
 tb/tb_ordena_frame_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ordena_frame_loader_pkg.sv
// Shared types and constants for the ordener2 front end.
// The frame loader and the sorter wrapper both import this package.
package ordena_pkg;

    localparam int DATA_W = 8;
    localparam int N_ELEM = 8;
    localparam int CNT_W  = 3;

    typedef logic [DATA_W-1:0] elem_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    // Max value, so padding lands at the top of an ascending sort.
    localparam elem_t PAD_VAL_DEFAULT = '1;

endpackage : ordena_pkg

// File: rtl/ordena_frame_loader_if.sv
// Serial-in / frame-out bus of the ordena frame loader.
// Modport master is the producer/consumer side; modport slave is the loader.
interface ordena_frame_loader_if #(
    parameter int DATA_W = ordena_pkg::DATA_W
);
    // Handshake rule for both channels: a transfer happens on a rising clk
    // edge where valid && ready are both 1. A source keeps valid and its
    // payload stable until the transfer; ready may change at any time.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] a, b, c, d, e, f, g, h;
    logic [3:0]        frame_len;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, a, b, c, d, e, f, g, h, frame_len
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, a, b, c, d, e, f, g, h, frame_len
    );

endinterface : ordena_frame_loader_if

// File: rtl/ordena_frame_loader.sv
// Packs a serial element stream into 8-slot frames for the ordener2 sorter,
// padding short frames with PAD_VAL and holding each frame until released.
module ordena_frame_loader
    import ordena_pkg::*;
#(
    parameter int                DATA_W  = ordena_pkg::DATA_W,
    parameter logic [DATA_W-1:0] PAD_VAL = DATA_W'(PAD_VAL_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    ordena_frame_loader_if.slave     bus,
    output loader_state_t            state_o,
    output logic [CNT_W-1:0]         count_o
);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        frame_len_q, frame_len_d;
    logic [DATA_W-1:0] slot_q [N_ELEM];
    logic [DATA_W-1:0] slot_d [N_ELEM];

    logic in_ready;
    logic accept;
    logic release_frame;
    logic closing;

    // in_ready is the only combinational output; in FULL it mirrors out_ready
    // so a new element can enter in the same cycle the old frame leaves.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = (state_q == FILL) ? 1'b1 : bus.out_ready;
        end
    end

    assign accept        = bus.in_valid && in_ready;
    assign release_frame = (state_q == FULL) && bus.out_ready;
    assign closing       = bus.in_last || (count_q == CNT_W'(N_ELEM - 1));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        frame_len_d = frame_len_q;
        for (int i = 0; i < N_ELEM; i++) begin
            slot_d[i] = slot_q[i];
        end

        if (flush) begin
            state_d     = FILL;
            count_d     = '0;
            frame_len_d = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (accept) begin
                        slot_d[count_q] = bus.in_data;
                        if (closing) begin
                            for (int i = 0; i < N_ELEM; i++) begin
                                if (i > int'(count_q)) begin
                                    slot_d[i] = PAD_VAL;
                                end
                            end
                            frame_len_d = {1'b0, count_q} + 4'd1;
                            count_d     = '0;
                            state_d     = FULL;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (release_frame) begin
                        if (accept) begin
                            // Consumer samples the old slots this cycle, so
                            // overwriting slot 0 on the same edge is safe.
                            slot_d[0] = bus.in_data;
                            if (bus.in_last) begin
                                for (int i = 1; i < N_ELEM; i++) begin
                                    slot_d[i] = PAD_VAL;
                                end
                                frame_len_d = 4'd1;
                                count_d     = '0;
                                state_d     = FULL;
                            end else begin
                                count_d = CNT_W'(1);
                                state_d = FILL;
                            end
                        end else begin
                            count_d = '0;
                            state_d = FILL;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            count_q     <= '0;
            frame_len_q <= '0;
            for (int i = 0; i < N_ELEM; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            frame_len_q <= frame_len_d;
            for (int i = 0; i < N_ELEM; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.frame_len = frame_len_q;
    assign bus.a         = slot_q[0];
    assign bus.b         = slot_q[1];
    assign bus.c         = slot_q[2];
    assign bus.d         = slot_q[3];
    assign bus.e         = slot_q[4];
    assign bus.f         = slot_q[5];
    assign bus.g         = slot_q[6];
    assign bus.h         = slot_q[7];

    assign state_o = state_q;
    assign count_o = count_q;

endmodule : ordena_frame_loader

// File: tb/tb_ordena_frame_loader.sv
// Directed scoreboard bench for ordena_frame_loader: expected frames are
// queued at stimulus time and popped by a monitor on each frame release.
module tb_ordena_frame_loader;
    import ordena_pkg::*;

    localparam int FW = 8 * 8 + 4;

    logic clk;
    logic rst_n;
    logic flush;
    loader_state_t   state_o;
    logic [CNT_W-1:0] count_o;

    ordena_frame_loader_if #(.DATA_W(8)) bus ();

    ordena_frame_loader #(.DATA_W(8), .PAD_VAL(8'hFF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus),
        .state_o (state_o),
        .count_o (count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [FW-1:0] exp_q[$];

    logic [FW-1:0] dut_frame;
    assign dut_frame = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h, bus.frame_len};

    function automatic logic [FW-1:0] pack8(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7,
                                            input logic [3:0] len);
        return {v0, v1, v2, v3, v4, v5, v6, v7, len};
    endfunction

    function automatic logic [FW-1:0] seq_frame(input logic [7:0] base);
        return pack8(base, base + 8'd1, base + 8'd2, base + 8'd3,
                     base + 8'd4, base + 8'd5, base + 8'd6, base + 8'd7, 4'd8);
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compares every released frame
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL release_unexpected: got frame %h with empty expected queue", dut_frame);
            end else begin
                logic [FW-1:0] e;
                e = exp_q.pop_front();
                if (dut_frame !== e) begin
                    bad++;
                    $display("FAIL release_frame: got %h expected %h", dut_frame, e);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send8(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            send(base + 8'(i), 1'b0);
        end
    endtask

    task automatic release_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_release", FW'(bus.out_valid), FW'(0));
    endtask

    initial begin
        int ov_seen;
        logic rdy_ok;
        logic [FW-1:0] held;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // reset state
        check("in_ready_in_reset", FW'(bus.in_ready), FW'(0));
        check("out_valid_reset", FW'(bus.out_valid), FW'(0));
        check("frame_reset", dut_frame, FW'(0));
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", FW'(bus.in_ready), FW'(1));

        // full frame held with out_ready low
        send8(8'h10);
        exp_q.push_back(seq_frame(8'h10));
        check("full_out_valid", FW'(bus.out_valid), FW'(1));
        check("full_frame", dut_frame, seq_frame(8'h10));
        check("full_in_ready_low", FW'(bus.in_ready), FW'(0));
        held = dut_frame;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            tick();
            check("hold_stable", {dut_frame[FW-1:1], bus.out_valid}, {held[FW-1:1], 1'b1});
        end
        bus.in_valid = 1'b0;
        release_one();

        // short frame padded with FF
        send(8'h05, 1'b0);
        send(8'h03, 1'b0);
        check("short_not_yet_valid", FW'(bus.out_valid), FW'(0));
        send(8'h09, 1'b1);
        exp_q.push_back(pack8(8'h05, 8'h03, 8'h09, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd3));
        check("short_out_valid", FW'(bus.out_valid), FW'(1));
        check("short_frame", dut_frame,
              pack8(8'h05, 8'h03, 8'h09, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd3));
        release_one();

        // back-to-back stream, 16 bytes, consumer always ready
        bus.out_ready = 1'b1;
        exp_q.push_back(seq_frame(8'h20));
        exp_q.push_back(seq_frame(8'h28));
        ov_seen = 0;
        rdy_ok  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h20 + 8'(i);
            bus.in_last  = 1'b0;
            #1;
            if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
            if (bus.out_valid === 1'b1) ov_seen++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("b2b_second_valid", FW'(bus.out_valid), FW'(1));
        ov_seen++;
        tick();
        bus.out_ready = 1'b0;
        check("b2b_in_ready_never_low", FW'(rdy_ok), FW'(1));
        check("b2b_out_valid_cycles", FW'(ov_seen), FW'(2));
        check("b2b_idle_after", FW'(bus.out_valid), FW'(0));

        // release-cycle accept carrying in_last
        send8(8'h30);
        exp_q.push_back(seq_frame(8'h30));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h42;
        bus.in_last   = 1'b1;
        exp_q.push_back(pack8(8'h42, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd1));
        tick();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        check("single_out_valid", FW'(bus.out_valid), FW'(1));
        check("single_frame", dut_frame,
              pack8(8'h42, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd1));
        release_one();

        // flush after 4 accepts, with a 5th element offered in the flush cycle
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h54;
        flush        = 1'b1;
        #1;
        check("flush_in_ready", FW'(bus.in_ready), FW'(1));
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_no_valid", FW'(bus.out_valid), FW'(0));
        check("flush_frame_len", FW'(bus.frame_len), FW'(0));
        send8(8'h60);
        exp_q.push_back(seq_frame(8'h60));
        check("post_flush_frame", dut_frame, seq_frame(8'h60));
        release_one();

        // reset while FULL drops the held frame
        send8(8'h70);
        check("pre_reset_full", FW'(bus.out_valid), FW'(1));
        rst_n = 1'b0;
        #1;
        check("in_ready_during_reset", FW'(bus.in_ready), FW'(0));
        tick();
        rst_n = 1'b1;
        check("midreset_out_valid", FW'(bus.out_valid), FW'(0));
        check("midreset_frame", dut_frame, FW'(0));

        // in_last on the 8th element behaves as a plain full frame
        for (int i = 0; i < 7; i++) send(8'h80 + 8'(i), 1'b0);
        send(8'h87, 1'b1);
        exp_q.push_back(seq_frame(8'h80));
        check("last_at_8_frame", dut_frame, seq_frame(8'h80));
        release_one();

        tick();
        check("scoreboard_drained", FW'(exp_q.size()), FW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_ordena_frame_loader
